// File: rtl/aes_pkg.sv
// Shared types and constants for the AES request arbiter.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] AES_MODE_128     = 2'b00;
  localparam logic [1:0] AES_MODE_192     = 2'b01;
  localparam logic [1:0] AES_MODE_256     = 2'b10;
  localparam logic [1:0] AES_MODE_ILLEGAL = 2'b11;

  // Watchdog counter width; covers TIMEOUT up to 255.
  localparam int unsigned WD_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester set, searching upward from last_grant+1 with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            none
);

  int unsigned      cand;
  logic [IDW-1:0]   cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    none     = 1'b1;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = 32'(last_grant) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (none && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
        none            = 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NREQ requesters: round-robin accept, start pulse,
// watchdog-bounded wait for done, tagged response.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = $clog2(NREQ),
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_enc_dec,
  input  logic [NREQ-1:0][1:0]   req_mode,
  input  logic [NREQ-1:0][255:0] req_key,
  input  logic [NREQ-1:0][127:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic                   core_enc_dec,
  output logic [1:0]             core_mode,
  output logic [255:0]           core_key,
  output logic [127:0]           core_data_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_done
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   cur_id;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic             gnt_none;
  logic [WD_W-1:0]  wd_cnt;
  logic             accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt_oh),
    .idx        (gnt_idx),
    .none       (gnt_none)
  );

  // Ready is offered only in IDLE and is forced low while reset is held.
  assign accept    = (state == IDLE) && !gnt_none;
  assign req_ready = ((state == IDLE) && reset) ? gnt_oh : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      cur_id       <= '0;
      wd_cnt       <= '0;
      core_start   <= 1'b0;
      core_enc_dec <= 1'b0;
      core_mode    <= '0;
      core_key     <= '0;
      core_data_in <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            core_enc_dec <= req_enc_dec[gnt_idx];
            core_mode    <= req_mode[gnt_idx];
            core_key     <= req_key[gnt_idx];
            core_data_in <= req_data[gnt_idx];
            cur_id       <= gnt_idx;
            last_grant   <= gnt_idx;
            // Illegal mode is answered directly; the core never sees it.
            if (req_mode[gnt_idx] == AES_MODE_ILLEGAL) begin
              rsp_valid <= 1'b1;
              rsp_id    <= gnt_idx;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              core_start <= 1'b1;
              state      <= START;
            end
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          // done has priority over a watchdog expiry in the same cycle
          if (core_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= core_data_out;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed and randomized bench for aes_req_arbiter with a behavioural AES core stand-in.
module tb_aes_req_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_enc_dec;
  logic [NREQ-1:0][1:0]   req_mode;
  logic [NREQ-1:0][255:0] req_key;
  logic [NREQ-1:0][127:0] req_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [127:0]           rsp_data;
  logic                   rsp_err;
  logic                   core_start;
  logic                   core_enc_dec;
  logic [1:0]             core_mode;
  logic [255:0]           core_key;
  logic [127:0]           core_data_in;
  logic [127:0]           core_data_out;
  logic                   core_done;

  int checks   = 0;
  int errors   = 0;
  int core_lat = 1;   // 0: the core never signals done
  int core_rem = 0;
  int last     = NREQ - 1;
  int got_id   = 0;
  logic [127:0] got_data;

  always #5 clk = ~clk;

  aes_req_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_enc_dec   (req_enc_dec),
    .req_mode      (req_mode),
    .req_key       (req_key),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .core_start    (core_start),
    .core_enc_dec  (core_enc_dec),
    .core_mode     (core_mode),
    .core_key      (core_key),
    .core_data_in  (core_data_in),
    .core_data_out (core_data_out),
    .core_done     (core_done)
  );

  // Stand-in cipher: the FIPS-197 vector is exact, anything else is a keyed scramble.
  function automatic logic [127:0] core_fn(input logic ed, input logic [1:0] m,
                                           input logic [255:0] k, input logic [127:0] d);
    if (!ed && m == 2'b00 && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {d[63:0], d[127:64]} ^ k[127:0] ^ k[255:128] ^ {125'd0, ed, m};
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] m);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (last + i) % NREQ;
      if (m[c[IDW-1:0]]) return c;
    end
    return -1;
  endfunction

  // Core model: done arrives core_lat cycles after the start pulse.
  initial begin
    core_done     = 1'b0;
    core_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_rem > 0) begin
        core_rem--;
        if (core_rem == 0) begin
          core_done     = 1'b1;
          core_data_out = core_fn(core_enc_dec, core_mode, core_key, core_data_in);
        end
      end
      if (core_start && core_lat > 0) core_rem = core_lat;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic ed, input logic [1:0] m,
                           input logic [255:0] k, input logic [127:0] d);
    req_enc_dec[i] = ed;
    req_mode[i]    = m;
    req_key[i]     = k;
    req_data[i]    = d;
  endtask

  task automatic rand_req(input int i, input bit allow_illegal);
    logic [1:0] m;
    m = 2'($urandom_range(0, allow_illegal ? 3 : 2));
    drive_req(i, 1'($urandom), m,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp", 256'({rsp_valid, rsp_err, rsp_id, rsp_data}), '0);
    chk("rst_core", 256'({core_start, core_enc_dec, core_mode, core_data_in}), '0);
    chk("rst_core_key", core_key, '0);
    chk("rst_req_ready", 256'(req_ready), '0);
  endtask

  // One transaction from the IDLE cycle with inputs already driven to the response handshake.
  task automatic job(input int lat, input int hold);
    int g, c, exp_c, starts;
    logic [NREQ-1:0] oh;
    logic [255:0] k;
    logic [127:0] d, exp_d;
    logic [1:0] m;
    logic ed, exp_e, illegal;
    core_lat = lat;
    #1;
    g  = exp_grant(req_valid);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    else g = 0;
    chk("req_ready_grant", 256'(req_ready), 256'(oh));
    ed      = req_enc_dec[g];
    m       = req_mode[g];
    k       = req_key[g];
    d       = req_data[g];
    illegal = (m == 2'b11);
    exp_e   = illegal || lat == 0 || lat > TIMEOUT;
    exp_d   = exp_e ? '0 : core_fn(ed, m, k, d);
    exp_c   = illegal ? 0 : (exp_e ? TIMEOUT + 1 : lat + 1);
    last    = g;
    cyc();
    if (illegal) begin
      chk("no_core_start", 256'(core_start), '0);
    end else begin
      chk("core_start", 256'(core_start), 256'(1));
      chk("core_operands", 256'({core_enc_dec, core_mode, core_data_in}), 256'({ed, m, d}));
      chk("core_key", core_key, k);
    end
    c = 0;
    starts = 0;
    while (!rsp_valid && c < 300) begin
      cyc();
      c++;
      starts += int'(core_start);
    end
    chk("rsp_latency", 256'(c), 256'(exp_c));
    chk("start_single_pulse", 256'(starts), '0);
    chk("rsp_id", 256'(rsp_id), 256'(g));
    chk("rsp_data", 256'(rsp_data), 256'(exp_d));
    chk("rsp_err", 256'(rsp_err), 256'(exp_e));
    got_id   = int'(rsp_id);
    got_data = rsp_data;
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_rsp", 256'({rsp_valid, rsp_id, rsp_data, rsp_err}),
          256'({1'b1, IDW'(g), exp_d, exp_e}));
      chk("hold_req_ready", 256'(req_ready), '0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 256'(rsp_valid), '0);
  endtask

  initial begin
    reset       = 1'b0;
    rsp_ready   = 1'b0;
    req_enc_dec = '0;
    req_mode    = '0;
    req_key     = '0;
    req_data    = '0;
    req_valid   = '1;
    cyc();
    cyc();
    chk_reset_outputs();
    req_valid = '0;
    reset     = 1'b1;
    cyc();

    // FIPS-197 AES-128 vector on requester 0
    drive_req(0, 1'b0, 2'b00, FIPS_KEY, FIPS_PT);
    req_valid = 4'b0001;
    job(5, 0);
    req_valid = '0;
    chk("fips_ct", 256'(got_data), 256'(FIPS_CT));

    // All requesters valid: grants rotate starting after requester 0
    for (int i = 0; i < NREQ; i++) rand_req(i, 1'b0);
    req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      job(int'($urandom_range(1, 4)), 0);
      chk("fair_order", 256'(got_id), 256'((j + 1) % NREQ));
    end
    req_valid = '0;

    // Illegal mode on requester 2
    rand_req(2, 1'b0);
    req_mode[2] = 2'b11;
    req_valid   = 4'b0100;
    job(3, 0);
    req_valid = '0;

    // Watchdog: no done, done on the expiry cycle, done one cycle too late
    rand_req(1, 1'b0);
    req_valid = 4'b0010;
    job(0, 0);
    job(TIMEOUT, 0);
    job(TIMEOUT + 1, 0);
    req_valid = '0;

    // Response back-pressure, then the next grant right after release
    rand_req(3, 1'b0);
    req_valid = 4'b1000;
    job(2, 10);
    job(1, 0);
    req_valid = '0;

    // Reset while BUSY drops the job and restores requester 0 priority
    for (int i = 0; i < NREQ; i++) rand_req(i, 1'b0);
    core_lat  = 0;
    req_valid = '1;
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    cyc();
    cyc();
    chk("no_rsp_after_drop", 256'(rsp_valid), '0);
    reset = 1'b1;
    last  = NREQ - 1;
    job(2, 0);
    chk("post_reset_first", 256'(got_id), '0);
    req_valid = '0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) rand_req(i, 1'b1);
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      job(int'($urandom_range(0, 18)), int'($urandom_range(0, 2)));
      req_valid = '0;
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one generalized AES core (enc/dec, 128/192/256-bit modes) between `NREQ` independent requesters. It accepts one request at a time over a valid/ready handshake and latches its operands. It then pulses the core's `start`, waits for the core's `done` under a watchdog, and returns the result tagged with the requester index. It sits directly in front of the AES core; the core's `start`, `enc_dec`, `mode`, `key` and `data_in` inputs are driven only by this block.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.
- `TIMEOUT`, default 32: cycles allowed in BUSY before an error is returned, 16..255.

Ports:
- `clk` — in — 1 — the single clock; all logic is on its rising edge.
- `reset` — in — 1 — asynchronous, active-low reset.
- `req_valid` — in — `NREQ` — per-requester request valid.
- `req_ready` — out — `NREQ` — per-requester accept; one-hot or zero.
- `req_enc_dec` — in — `[NREQ-1:0]` — 1 = decipher, 0 = encipher.
- `req_mode` — in — `[NREQ-1:0][1:0]` — 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
- `req_key` — in — `[NREQ-1:0][255:0]` — cipher key.
- `req_data` — in — `[NREQ-1:0][127:0]` — input block.
- `rsp_valid` — out — 1 — response valid.
- `rsp_ready` — in — 1 — response accepted.
- `rsp_id` — out — `IDW` — index of the requester that owns the response.
- `rsp_data` — out — 128 — result block.
- `rsp_err` — out — 1 — 1 = illegal mode or timeout.
- `core_start` — out — 1 — one-cycle start pulse to the core.
- `core_enc_dec` — out — 1 — to the core.
- `core_mode` — out — 2 — to the core.
- `core_key` — out — 256 — to the core.
- `core_data_in` — out — 128 — to the core.
- `core_data_out` — in — 128 — core result; combinational, sampled only when `core_done` is high.
- `core_done` — in — 1 — core completion.

## Operation
States:
- **IDLE**
  - Round-robin grant `g` is the first requester with `req_valid` set, searching from `last_grant+1` with wrap-around.
  - `req_ready[g]=1` combinationally; no other requester sees ready.
  - Handshake (`req_valid[g] & req_ready[g]`) latches `enc_dec`, `mode`, `key` and `data` into operand registers, latches `g` into `cur_id`, and sets `last_grant<=g`.
  - Legal mode: next state START.
  - Mode 11: next state RESP with `rsp_err=1` and `rsp_data=0`; the core is never started.
- **START**
  - `core_start=1` for exactly this cycle.
  - Clears the watchdog counter.
  - Next state BUSY.
- **BUSY**
  - Watchdog counter increments every cycle.
  - On `core_done=1`: capture `core_data_out` into `rsp_data`, `rsp_err=0`, next state RESP.
  - Else, when the counter reaches `TIMEOUT-1`: `rsp_data=0`, `rsp_err=1`, next state RESP.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins.
- **RESP**
  - `rsp_valid=1`; `rsp_id`, `rsp_data` and `rsp_err` are stable until the handshake.
  - On `rsp_ready=1`: next state IDLE.
  - No new request is accepted while in RESP.

Output rules:
- `core_*` operand outputs come straight from the operand registers and hold between jobs.
- `req_ready` is 0 in every state other than IDLE.
- `core_done` outside BUSY is ignored.

Reset (asynchronous, active-low):
- State goes to IDLE and `last_grant` to `NREQ-1`, so requester 0 has first priority.
- `rsp_valid`, `rsp_err`, `core_start` and `req_ready` go to 0; `rsp_id`, `rsp_data` and all operand registers go to 0.
- Asserting reset mid-job drops the job silently; no response is produced.

## Timing
- Accept at cycle T. `core_start` is high in T+1. Core latency k is measured from the start pulse: `core_done` arrives in T+1+k. `rsp_valid` is high from T+2+k.
- Back-to-back throughput: the next accept can occur at the earliest in the cycle after the `rsp_ready` handshake.
- Fairness: with all requesters continuously valid, grants cycle 0, 1, …, `NREQ-1`, 0, ….
- Watchdog: with no `core_done`, `rsp_valid` rises `TIMEOUT+1` cycles after `core_start`.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum `arb_state_t` {IDLE, START, BUSY, RESP};
  - mode constants `AES_MODE_128/192/256/ILLEGAL`.
- Sub-module `rr_arbiter`: parameterized by `NREQ`. It takes the request vector and `last_grant` and produces a one-hot grant, the index `g`, and a `none` flag.

## Test plan
- Reset, then `req_valid=0001`, mode 00, enc, FIPS-197 key `000102…0f`, data `00112233…eeff`:
  - `core_start` is 1 cycle after the accept;
  - `rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a`, `rsp_id=0`, `rsp_err=0`.
- All 4 requesters held valid for 8 jobs -> grant order 0,1,2,3,0,1,2,3; no `req_ready` overlap.
- `req_mode=11` on requester 2 -> accepted, `rsp_err=1`, `rsp_data=0`, `rsp_id=2`; `core_start` never pulses.
- Core model never asserts done, `TIMEOUT=16` -> `rsp_valid` 17 cycles after `core_start`, `rsp_err=1`.
- Hold `rsp_ready=0` for 10 cycles -> `rsp_*` stable and `req_ready=0` throughout; the next grant follows the release.
- Assert reset while in BUSY -> all outputs 0 immediately; no `rsp_valid` for the dropped job; requester 0 has first priority after release.
